// File: rtl/d_branch_unit.sv
// d_branch_unit: decode-stage branch resolver with a 2-bit saturating predictor.
//
// Resolves the branch condition of the D-stage instruction combinationally and
// looks up a per-PC 2-bit counter table (PHT) for the taken prediction.
// Counters train on every non-stalled branch.
//
// Optional feature macro: BRANCH_STATS_EN
//   When defined, adds 32-bit wrapping branch and mispredict counters
//   (br_cnt, miss_cnt). When undefined, those ports and registers are absent.
//
// Ports:
//   clk         sole clock, rising edge
//   reset       asynchronous active-low reset
//   req         branch present in D this cycle
//   stall       D stalled; table and counters hold
//   Rd1, Rd2    forwarded rs / rt operands (WIDTH bits)
//   CmpOp       comparison select
//   pc          PC of the D-stage instruction
//   Flag        resolved branch condition (combinational)
//   pred_taken  predictor output for pc (combinational)
//   mispredict  req & (pred_taken ^ Flag) (combinational)
//   br_cnt      branches retired from D (BRANCH_STATS_EN only)
//   miss_cnt    mispredicted branches (BRANCH_STATS_EN only)

module d_branch_unit #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned PHT_DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             stall,
  input  logic [WIDTH-1:0] Rd1,
  input  logic [WIDTH-1:0] Rd2,
  input  logic [3:0]       CmpOp,
  input  logic [31:0]      pc,
  output logic             Flag,
  output logic             pred_taken,
  output logic             mispredict
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]      br_cnt,
  output logic [31:0]      miss_cnt
`endif
);

  localparam int unsigned IDX_W = $clog2(PHT_DEPTH);

  logic [IDX_W-1:0] idx;
  logic [1:0]       pht [PHT_DEPTH];
  logic [1:0]       cur_ctr;
  logic [1:0]       nxt_ctr;
  logic             upd;
  logic             rd1_neg;
  logic             rd1_zero;
  logic             unused_pc;

  // Only word-aligned index bits select an entry; the rest of pc is ignored.
  assign idx       = pc[IDX_W+1:2];
  assign unused_pc = ^{pc[31:IDX_W+2], pc[1:0]};

  assign rd1_neg  = Rd1[WIDTH-1];
  assign rd1_zero = (Rd1 == '0);

  // Branch condition decode; all ordering comparisons are signed.
  always_comb begin
    Flag = 1'b0;
    case (CmpOp)
      4'd1:    Flag = (Rd1 == Rd2);
      4'd2:    Flag = (Rd1 != Rd2);
      4'd3:    Flag = ~rd1_neg;
      4'd4:    Flag = ~rd1_neg & ~rd1_zero;
      4'd5:    Flag = rd1_neg | rd1_zero;
      4'd6:    Flag = rd1_neg;
      4'd7:    Flag = ($signed(Rd1) <  $signed(Rd2));
      4'd8:    Flag = ($signed(Rd1) >= $signed(Rd2));
      default: Flag = 1'b0;
    endcase
  end

  // Prediction reads the pre-edge table contents.
  assign cur_ctr    = pht[idx];
  assign pred_taken = cur_ctr[1];
  assign mispredict = req & (pred_taken ^ Flag);
  assign upd        = req & ~stall;

  // Saturating counter step toward the resolved outcome.
  always_comb begin
    nxt_ctr = cur_ctr;
    if (Flag) begin
      if (cur_ctr != 2'b11) nxt_ctr = cur_ctr + 2'd1;
    end else begin
      if (cur_ctr != 2'b00) nxt_ctr = cur_ctr - 2'd1;
    end
  end

  // Pattern history table; reset to weakly not-taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(PHT_DEPTH); i++) begin
        pht[i] <= 2'b01;
      end
    end else if (upd) begin
      pht[idx] <= nxt_ctr;
    end
  end

`ifdef BRANCH_STATS_EN
  // Branch / mispredict statistics, wrapping at 2^32.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      br_cnt   <= 32'd0;
      miss_cnt <= 32'd0;
    end else if (upd) begin
      br_cnt <= br_cnt + 32'd1;
      if (mispredict) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_d_branch_unit.sv
// Directed testbench for d_branch_unit (WIDTH=32, PHT_DEPTH=16).
// Counter checks are included when BRANCH_STATS_EN is defined.

module tb_d_branch_unit;

  localparam int unsigned WIDTH     = 32;
  localparam int unsigned PHT_DEPTH = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             req;
  logic             stall;
  logic [WIDTH-1:0] Rd1;
  logic [WIDTH-1:0] Rd2;
  logic [3:0]       CmpOp;
  logic [31:0]      pc;
  logic             Flag;
  logic             pred_taken;
  logic             mispredict;
`ifdef BRANCH_STATS_EN
  logic [31:0]      br_cnt;
  logic [31:0]      miss_cnt;
  int unsigned      exp_br   = 0;
  int unsigned      exp_miss = 0;
`endif

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  d_branch_unit #(
    .WIDTH     (WIDTH),
    .PHT_DEPTH (PHT_DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .stall      (stall),
    .Rd1        (Rd1),
    .Rd2        (Rd2),
    .CmpOp      (CmpOp),
    .pc         (pc),
    .Flag       (Flag),
    .pred_taken (pred_taken),
    .mispredict (mispredict)
`ifdef BRANCH_STATS_EN
    ,
    .br_cnt     (br_cnt),
    .miss_cnt   (miss_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one input vector, then let combinational outputs settle.
  task automatic drive(input logic r, input logic s, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] p);
    req = r; stall = s; CmpOp = op; Rd1 = a; Rd2 = b; pc = p;
    #1;
  endtask

  // Check the current vector against hand-computed Flag / prediction, then clock once.
  task automatic cyc(input string tag, input logic ef, input logic ep);
    logic em;
    em = req & (ef ^ ep);
    chk({tag, ".flag"}, 32'(Flag), 32'(ef));
    chk({tag, ".pred"}, 32'(pred_taken), 32'(ep));
    chk({tag, ".miss"}, 32'(mispredict), 32'(em));
`ifdef BRANCH_STATS_EN
    chk({tag, ".brc"}, br_cnt, exp_br);
    chk({tag, ".mic"}, miss_cnt, exp_miss);
    if (reset && req && !stall) begin
      exp_br++;
      if (em) exp_miss++;
    end
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; req = 1'b0; stall = 1'b0; CmpOp = 4'd0;
    Rd1 = '0; Rd2 = '0; pc = 32'h0;
    #2;
    chk("rst_idle.pred", 32'(pred_taken), 32'd0);
    chk("rst_idle.miss", 32'(mispredict), 32'd0);

    // Taken branch under reset: no training across these edges.
    drive(1'b1, 1'b0, 4'd1, 32'd5, 32'd5, 32'h3000);
    cyc("rst_a", 1'b1, 1'b0);
    cyc("rst_b", 1'b1, 1'b0);
    reset = 1'b1;

    // First trained branch: 01 -> 10, then saturate upward.
    cyc("first", 1'b1, 1'b0);
    cyc("tk1", 1'b1, 1'b1);
    cyc("tk2", 1'b1, 1'b1);
    cyc("tk3", 1'b1, 1'b1);
    cyc("tk4", 1'b1, 1'b1);
    // Not-taken (bne on equal operands): 3 -> 2 -> 1 -> 0.
    drive(1'b1, 1'b0, 4'd2, 32'd5, 32'd5, 32'h3000);
    cyc("nt1", 1'b0, 1'b1);
    cyc("nt2", 1'b0, 1'b1);
    cyc("nt3", 1'b0, 1'b0);

    // Aliasing: 0x3040 shares entry 0 with 0x3000 (entry currently 0).
    drive(1'b1, 1'b0, 4'd1, 32'd9, 32'd9, 32'h3040);
    cyc("alias_a", 1'b1, 1'b0);
    cyc("alias_b", 1'b1, 1'b0);
    drive(1'b0, 1'b0, 4'd1, 32'd9, 32'd9, 32'h3000);
    cyc("alias_c", 1'b1, 1'b1);

    // Comparison decode, req=0 so no training (entry 0 stays 2).
    drive(1'b0, 1'b0, 4'd6, 32'h8000_0000, 32'd0, 32'h3000);
    cyc("bltz_min", 1'b1, 1'b1);
    drive(1'b0, 1'b0, 4'd3, 32'h8000_0000, 32'd0, 32'h3000);
    cyc("bgez_min", 1'b0, 1'b1);
    drive(1'b0, 1'b0, 4'd7, 32'hFFFF_FFFF, 32'd1, 32'h3000);
    cyc("blt_sgn", 1'b1, 1'b1);
    drive(1'b0, 1'b0, 4'd8, 32'hFFFF_FFFF, 32'd1, 32'h3000);
    cyc("bge_sgn", 1'b0, 1'b1);
    drive(1'b0, 1'b0, 4'd8, 32'd7, 32'd7, 32'h3000);
    cyc("bge_eq", 1'b1, 1'b1);
    drive(1'b0, 1'b0, 4'd2, 32'd5, 32'd6, 32'h3000);
    cyc("bne_ne", 1'b1, 1'b1);
    drive(1'b0, 1'b0, 4'd4, 32'd0, 32'd0, 32'h3000);
    cyc("bgtz_0", 1'b0, 1'b1);
    drive(1'b0, 1'b0, 4'd4, 32'd1, 32'd0, 32'h3000);
    cyc("bgtz_1", 1'b1, 1'b1);
    drive(1'b0, 1'b0, 4'd5, 32'd0, 32'd0, 32'h3000);
    cyc("blez_0", 1'b1, 1'b1);
    drive(1'b0, 1'b0, 4'd5, 32'h7FFF_FFFF, 32'd0, 32'h3000);
    cyc("blez_max", 1'b0, 1'b1);
    drive(1'b0, 1'b0, 4'd0, 32'd3, 32'd3, 32'h3000);
    cyc("op0", 1'b0, 1'b1);
    drive(1'b0, 1'b0, 4'd9, 32'd3, 32'd3, 32'h3000);
    cyc("op9", 1'b0, 1'b1);
    drive(1'b0, 1'b0, 4'd15, 32'h8000_0000, 32'd3, 32'h3000);
    cyc("op15", 1'b0, 1'b1);

    // Stall freezes entry 1 (01) although mispredict is asserted.
    drive(1'b1, 1'b1, 4'd1, 32'd7, 32'd7, 32'h3004);
    cyc("stall1", 1'b1, 1'b0);
    cyc("stall2", 1'b1, 1'b0);
    cyc("stall3", 1'b1, 1'b0);
    drive(1'b0, 1'b0, 4'd1, 32'd7, 32'd7, 32'h3004);
    cyc("unstall_idle", 1'b1, 1'b0);
    drive(1'b1, 1'b0, 4'd1, 32'd7, 32'd7, 32'h3004);
    cyc("unstall_upd", 1'b1, 1'b0);
    cyc("unstall_seen", 1'b1, 1'b1);

    // Lower saturation on entry 2 (01): 1 -> 0 -> 0, then 0 -> 1 -> 2.
    drive(1'b1, 1'b0, 4'd2, 32'd5, 32'd5, 32'h3008);
    cyc("dn1", 1'b0, 1'b0);
    cyc("dn2", 1'b0, 1'b0);
    drive(1'b1, 1'b0, 4'd1, 32'd5, 32'd5, 32'h3008);
    cyc("up1", 1'b1, 1'b0);
    cyc("up2", 1'b1, 1'b0);
    drive(1'b0, 1'b0, 4'd1, 32'd5, 32'd5, 32'h3008);
    cyc("up_seen", 1'b1, 1'b1);

    // Asynchronous reset mid-cycle clears table (and counters) without a clock.
    drive(1'b0, 1'b0, 4'd1, 32'd5, 32'd5, 32'h3000);
    reset = 1'b0;
    #1;
    chk("async_rst.pred", 32'(pred_taken), 32'd0);
`ifdef BRANCH_STATS_EN
    chk("async_rst.brc", br_cnt, 32'd0);
    chk("async_rst.mic", miss_cnt, 32'd0);
    exp_br   = 0;
    exp_miss = 0;
`endif
    #2;
    reset = 1'b1;
    drive(1'b0, 1'b0, 4'd1, 32'd5, 32'd5, 32'h3008);
    cyc("post_rst", 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/d_branch_unit.md
D_BRANCH_UNIT -- requirements
Module: d_branch_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits.
REQ-002 SHALL have parameter PHT_DEPTH, default 16, number of 2-bit predictor entries; power of two, at least 2.
REQ-003 SHALL have port clk, input, 1 bit, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, asynchronous active-low reset; 0 = reset.
REQ-005 SHALL have port req, input, 1 bit, a branch instruction is present in D this cycle.
REQ-006 SHALL have port stall, input, 1 bit, D is stalled; the predictor table and counters are frozen.
REQ-007 SHALL have port Rd1, input, WIDTH bits, forwarded rs operand.
REQ-008 SHALL have port Rd2, input, WIDTH bits, forwarded rt operand.
REQ-009 SHALL have port CmpOp, input, 4 bits, comparison select.
REQ-010 SHALL have port pc, input, 32 bits, PC of the D-stage instruction.
REQ-011 SHALL have port Flag, output, 1 bit, resolved branch condition.
REQ-012 SHALL have port pred_taken, output, 1 bit, predictor output for pc.
REQ-013 SHALL have port mispredict, output, 1 bit, req and prediction differs from Flag.
REQ-014 SHALL have ports br_cnt and miss_cnt, output, 32 bits each, present only under the macro in REQ-029.

Function
REQ-015 SHALL decode CmpOp as: 1 beq (Rd1==Rd2); 2 bne (Rd1!=Rd2); 3 bgez (Rd1>=0); 4 bgtz (Rd1>0); 5 blez (Rd1<=0); 6 bltz (Rd1<0); 7 blt (Rd1<Rd2); 8 bge (Rd1>=Rd2).
REQ-016 SHALL perform every ordering comparison as two's-complement signed at WIDTH bits.
REQ-017 SHALL drive Flag=0 for CmpOp 0 and 9-15.
REQ-018 SHALL make Flag combinational: zero-cycle latency, independent of req, stall and reset.
REQ-019 SHALL index the PHT with idx = pc[log2(PHT_DEPTH)+1:2].
REQ-020 SHALL drive pred_taken = PHT[idx][1], combinationally, from the pre-edge table contents.
REQ-021 SHALL drive mispredict = req & (pred_taken ^ Flag), combinationally.
REQ-022 SHALL update PHT[idx] at the clock edge only when req=1 and stall=0.
- Flag=1: saturating increment, max 3.
- Flag=0: saturating decrement, min 0.
REQ-023 SHALL leave the other entries and the selected entry unchanged when req=0 or stall=1.
REQ-024 SHALL update an entry at most once per cycle; a read of the same idx in the update cycle returns the old value, and the new value is visible the next cycle.

Reset
REQ-025 SHALL, while reset=0, asynchronously set every PHT entry to 2'b01 (weakly not-taken).
REQ-026 SHALL, while reset=0, asynchronously clear br_cnt and miss_cnt to 0.
REQ-027 SHALL, during reset, drive pred_taken=0 and mispredict=req&Flag, as follows from REQ-020/021; Flag keeps following its operands.
REQ-028 SHALL let reset asserted mid-operation override any pending update in that cycle; operation resumes on the first rising edge after reset deasserts.

Configuration
REQ-029 SHALL compile the statistics counters only when BRANCH_STATS_EN is defined.
- Defined: br_cnt increments on each edge with req=1 and stall=0; miss_cnt increments when additionally mispredict=1; both wrap from 2^32-1 to 0.
- Undefined: ports br_cnt/miss_cnt and their registers are absent; all other behaviour is identical.

Verification
REQ-030 SHALL cover: reset, then req=1, CmpOp=1, Rd1=Rd2=5, pc=0x3000, stall=0 -> Flag=1, pred_taken=0, mispredict=1; next cycle PHT[0]=2'b10, pred_taken=1.
REQ-031 SHALL cover: CmpOp=6, Rd1=0x80000000 -> Flag=1; CmpOp=3, same Rd1 -> Flag=0; CmpOp=7, Rd1=0xFFFFFFFF, Rd2=1 -> Flag=1 (signed).
REQ-032 SHALL cover: four consecutive taken updates at one pc -> entry saturates at 3; one not-taken -> entry 2, pred_taken stays 1.
REQ-033 SHALL cover: req=1, stall=1 for 3 cycles with Flag=1 -> PHT unchanged, br_cnt unchanged; mispredict still asserted combinationally.
REQ-034 SHALL cover: pcs 0x3000 and 0x3040 with PHT_DEPTH=16 alias to idx 0 -> an update through one is seen through the other.
REQ-035 SHALL cover, with BRANCH_STATS_EN: miss_cnt preloaded via 2^32-1 mispredicting branches -> the next mispredict wraps miss_cnt to 0; reset=0 mid-run clears both counters immediately, without waiting for a clock.
